// File: rtl/mac_psum_pkg.sv
// Shared types and defaults for the MAC partial-sum unit.
package mac_psum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } psum_state_t;

  localparam int PSUM_SIZE_DEF = 20;

endpackage

// File: rtl/psum_out_fifo.sv
// Output buffer for finished partial sums: circular FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module psum_out_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_psum_unit.sv
// Two-stage multiply-accumulate producing one partial sum per par_done window.
// Define MAC_PSUM_SAT_EN to saturate the accumulator instead of wrapping.
module mac_psum_unit
  import mac_psum_pkg::*;
#(
  parameter int IF_CELL_SIZE     = 8,
  parameter int FILTER_CELL_SIZE = 8,
  parameter int PSUM_SIZE        = PSUM_SIZE_DEF,
  parameter int OUT_DEPTH        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        can_mult,
  input  logic                        par_done,
  input  logic [IF_CELL_SIZE-1:0]     if_data,
  input  logic [FILTER_CELL_SIZE-1:0] filter_data,
  output logic                        stall,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PSUM_SIZE-1:0]        out_data,
  output logic                        overflow,
  output logic                        busy
);

  localparam int PW = IF_CELL_SIZE + FILTER_CELL_SIZE;
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  function automatic logic [PSUM_SIZE-1:0] limit_sum(input logic [PSUM_SIZE:0] s);
`ifdef MAC_PSUM_SAT_EN
    return s[PSUM_SIZE] ? '1 : s[PSUM_SIZE-1:0];
`else
    return s[PSUM_SIZE-1:0];
`endif
  endfunction

  psum_state_t          state, state_next;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [PW-1:0]        prod_full;
  logic [PSUM_SIZE:0]   sum_full;
  logic [PSUM_SIZE-1:0] acc;
  logic [PSUM_SIZE-1:0] prod_p1;
  logic                 last_p1;
  logic                 vld_p1;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = vld_p1 && last_p1;
  // Hold off a new pair when the buffer will be full after the pending push.
  assign stall     = fifo_full ||
                     ((fifo_count == CW'(OUT_DEPTH - 1)) && push && !pop);
  assign accept    = can_mult && !stall;
  assign prod_full = PW'(if_data) * PW'(filter_data);
  assign sum_full  = {1'b0, acc} + {1'b0, prod_p1};
  assign busy      = (state == ACCUM) || vld_p1 || !fifo_empty;

  // Stage 1: register the product of the accepted pair
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      prod_p1 <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        last_p1 <= par_done;
        prod_p1 <= PSUM_SIZE'(prod_full);
      end
    end
  end

  // Stage 2: accumulate; a finished window leaves via the buffer and clears acc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (vld_p1) begin
      acc <= last_p1 ? '0 : limit_sum(sum_full);
      if (sum_full[PSUM_SIZE]) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !par_done) state_next = ACCUM;
      ACCUM:   if (accept && par_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  psum_out_fifo #(
    .WIDTH (PSUM_SIZE),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (limit_sum(sum_full)),
    .pop       (pop),
    .pop_data  (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_mac_psum_unit.sv
// Self-checking bench for mac_psum_unit: vector table, corner sequences,
// and randomized traffic against a window-sum reference model.
module tb_mac_psum_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        can_mult, par_done, out_ready;
  logic [7:0]  if_data, filter_data;
  logic        stall, out_valid, overflow, busy;
  logic [19:0] out_data;

  logic        cm16, pd16;
  logic [7:0]  a16, b16;
  logic        stall16, valid16, overflow16, busy16;
  logic [15:0] data16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_psum_unit #(
    .IF_CELL_SIZE(8), .FILTER_CELL_SIZE(8), .PSUM_SIZE(20), .OUT_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .can_mult(can_mult), .par_done(par_done),
    .if_data(if_data), .filter_data(filter_data), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .busy(busy)
  );

  mac_psum_unit #(
    .IF_CELL_SIZE(8), .FILTER_CELL_SIZE(8), .PSUM_SIZE(16), .OUT_DEPTH(4)
  ) dut16 (
    .clk(clk), .rst(rst), .can_mult(cm16), .par_done(pd16),
    .if_data(a16), .filter_data(b16), .stall(stall16),
    .out_valid(valid16), .out_ready(1'b1), .out_data(data16),
    .overflow(overflow16), .busy(busy16)
  );

  typedef struct {
    logic        cm;
    logic        pd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        rdy;
    logic        stall;
    logic        valid;
    logic [19:0] data;
  } vec_t;

  vec_t vt[$];

  // Reference model: sums per window, queue of finished sums not yet consumed
  longint q[$];
  longint win_sum  = 0;
  int     win_len  = 0;
  bit     pend     = 1'b0;
  longint pend_val = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input logic cm, input logic pd, input logic [7:0] a,
                       input logic [7:0] b, input logic rdy);
    can_mult    = cm;
    par_done    = pd;
    if_data     = a;
    filter_data = b;
    out_ready   = rdy;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic model_cycle(input logic cm, input logic pd, input logic [7:0] a,
                             input logic [7:0] b, input logic rdy);
    bit pop_e, stall_e, acc_e;
    apply(cm, pd, a, b, rdy);
    pop_e   = (q.size() > 0) && rdy;
    stall_e = (q.size() == 4) || ((q.size() == 3) && pend && !pop_e);
    check("rnd_stall", {31'd0, stall}, {31'd0, stall_e});
    check("rnd_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) check("rnd_data", {12'd0, out_data}, 32'(q[0]));
    acc_e = cm && !stall_e;
    if (pop_e) void'(q.pop_front());
    if (pend) q.push_back(pend_val);
    pend = acc_e && pd;
    if (acc_e) begin
      win_sum += longint'(a) * longint'(b);
      win_len++;
      if (pd) begin
        pend_val = win_sum;
        win_sum  = 0;
        win_len  = 0;
      end
    end
    next_cycle();
  endtask

  initial begin
    rst = 1'b0;
    cm16 = 1'b0; pd16 = 1'b0; a16 = '0; b16 = '0;
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (2) next_cycle();
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {12'd0, out_data}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    next_cycle();

    // Three-pair window: 2*3 + 4*5 + 1*7 = 33
    vt.push_back('{1'b1, 1'b0, 8'd2, 8'd3, 1'b1, 1'b0, 1'b0, 20'd0});
    vt.push_back('{1'b1, 1'b0, 8'd4, 8'd5, 1'b1, 1'b0, 1'b0, 20'd0});
    vt.push_back('{1'b1, 1'b1, 8'd1, 8'd7, 1'b1, 1'b0, 1'b0, 20'd0});
    vt.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 20'd0});
    vt.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 20'd33});
    vt.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 20'd0});
    // Five one-pair windows into a stalled consumer, then drain
    vt.push_back('{1'b1, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 20'd0});
    vt.push_back('{1'b1, 1'b1, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0, 20'd0});
    vt.push_back('{1'b1, 1'b1, 8'd3, 8'd1, 1'b0, 1'b0, 1'b1, 20'd1});
    vt.push_back('{1'b1, 1'b1, 8'd4, 8'd1, 1'b0, 1'b0, 1'b1, 20'd1});
    vt.push_back('{1'b1, 1'b1, 8'd5, 8'd1, 1'b0, 1'b1, 1'b1, 20'd1});
    vt.push_back('{1'b1, 1'b1, 8'd5, 8'd1, 1'b0, 1'b1, 1'b1, 20'd1});
    vt.push_back('{1'b1, 1'b1, 8'd5, 8'd1, 1'b0, 1'b1, 1'b1, 20'd1});
    vt.push_back('{1'b1, 1'b1, 8'd5, 8'd1, 1'b1, 1'b1, 1'b1, 20'd1});
    vt.push_back('{1'b1, 1'b1, 8'd5, 8'd1, 1'b1, 1'b0, 1'b1, 20'd2});
    vt.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 20'd3});
    vt.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 20'd4});
    vt.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1, 20'd5});
    vt.push_back('{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 20'd0});

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].cm, vt[i].pd, vt[i].a, vt[i].b, vt[i].rdy);
      check($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].stall});
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vt[i].valid});
      if (vt[i].valid) check($sformatf("vec%0d_data", i), {12'd0, out_data}, {12'd0, vt[i].data});
      next_cycle();
    end

    // Push and pop on the same edge while three sums are held
    apply(1'b1, 1'b1, 8'd10, 8'd1, 1'b0); next_cycle();
    apply(1'b1, 1'b1, 8'd20, 8'd1, 1'b0); next_cycle();
    apply(1'b1, 1'b1, 8'd30, 8'd1, 1'b0); next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b0); next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b0); next_cycle();
    apply(1'b1, 1'b1, 8'd40, 8'd1, 1'b0);
    check("pp_accept_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check("pp_stall", {31'd0, stall}, 32'd0);
    check("pp_head", {12'd0, out_data}, 32'd10);
    check("pp_busy", {31'd0, busy}, 32'd1);
    next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    check("pp_stall_after", {31'd0, stall}, 32'd0);
    check("pp_data0", {12'd0, out_data}, 32'd20);
    next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check("pp_data1", {12'd0, out_data}, 32'd20);
    next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check("pp_data2", {12'd0, out_data}, 32'd30);
    next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check("pp_data3", {12'd0, out_data}, 32'd40);
    next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check("pp_empty", {31'd0, out_valid}, 32'd0);
    check("pp_idle_busy", {31'd0, busy}, 32'd0);
    next_cycle();

    // 16-bit accumulator: 2 * 255*255 = 130050 exceeds 65535
    cm16 = 1'b1; pd16 = 1'b0; a16 = 8'd255; b16 = 8'd255; next_cycle();
    pd16 = 1'b1; next_cycle();
    cm16 = 1'b0; pd16 = 1'b0; next_cycle();
    #1;
    check("ovf16_valid", {31'd0, valid16}, 32'd1);
`ifdef MAC_PSUM_SAT_EN
    check("ovf16_data", {16'd0, data16}, 32'd65535);
`else
    check("ovf16_data", {16'd0, data16}, 32'd64514);
`endif
    check("ovf16_flag", {31'd0, overflow16}, 32'd1);
    check("ovf_main_clear", {31'd0, overflow}, 32'd0);
    next_cycle();

    // Reset in the middle of an open window
    apply(1'b1, 1'b0, 8'd5, 8'd5, 1'b1); next_cycle();
    apply(1'b1, 1'b0, 8'd6, 8'd6, 1'b1);
    check("win_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_data", {12'd0, out_data}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ovf16", {31'd0, overflow16}, 32'd0);
    next_cycle();
    rst = 1'b1;
    apply(1'b1, 1'b1, 8'd3, 8'd3, 1'b1); next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b1); next_cycle();
    apply(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_data", {12'd0, out_data}, 32'd9);
    check("post_rst_ovf", {31'd0, overflow}, 32'd0);
    next_cycle();

    // Randomized traffic; windows capped at 8 pairs so no overflow is possible
    for (int i = 0; i < 3000; i++) begin
      logic cm, pd, rdy;
      logic [7:0] a, b;
      cm  = ($urandom_range(0, 3) != 0);
      pd  = ($urandom_range(0, 2) == 0) || (win_len >= 7);
      a   = 8'($urandom);
      b   = 8'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      model_cycle(cm, pd, a, b, rdy);
    end
    for (int i = 0; i < 12; i++) model_cycle(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    #1;
    check("rnd_drained", {31'd0, out_valid}, 32'd0);
    check("rnd_busy", {31'd0, busy}, {31'd0, win_len != 0});
    check("rnd_overflow", {31'd0, overflow}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_psum_unit.md
MAC_PSUM_UNIT -- requirements
Module: mac_psum_unit

Interface
REQ-001 SHALL have parameter IF_CELL_SIZE, default 8, IF operand width.
REQ-002 SHALL have parameter FILTER_CELL_SIZE, default 8, filter operand width.
REQ-003 SHALL have parameter PSUM_SIZE, default 20, accumulator and out_data width.
REQ-004 SHALL have parameter OUT_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-005 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port can_mult, input, 1, operand pair valid this cycle.
REQ-008 SHALL have port par_done, input, 1, qualifies can_mult; pair is last of current window.
REQ-009 SHALL have port if_data, input, IF_CELL_SIZE, unsigned IF operand.
REQ-010 SHALL have port filter_data, input, FILTER_CELL_SIZE, unsigned filter operand.
REQ-011 SHALL have port stall, output, 1, back-pressure to checker; pair not accepted while high.
REQ-012 SHALL have port out_valid, output, 1, out_data holds a finished partial sum.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-014 SHALL have port out_data, output, PSUM_SIZE, oldest finished partial sum.
REQ-015 SHALL have port overflow, output, 1, sticky accumulator overflow flag.
REQ-016 SHALL have port busy, output, 1, window open, product in flight, or buffer non-empty.

Function
REQ-017 SHALL accept a pair when can_mult=1 and stall=0; otherwise inputs ignored.
REQ-018 SHALL register product if_data*filter_data (IF+FILTER bits, zero-extended to PSUM_SIZE) plus last=par_done at the accepting edge (stage 1).
REQ-019 SHALL, at the next edge, add the stage-1 product to acc (acc taken as 0 for first pair of a window) (stage 2).
REQ-020 SHALL, when stage-1 last=1, push the completed sum into the output buffer at that same edge and clear acc; latency from accepting last pair to out_valid=1 is exactly 2 edges.
REQ-021 SHALL implement FSM IDLE/ACCUM: IDLE->ACCUM on accepted pair with par_done=0; ACCUM->IDLE on accepted pair with par_done=1; accepted pair with par_done=1 in IDLE is a one-pair window, stays IDLE.
REQ-022 SHALL drive stall = (count==OUT_DEPTH) or (count==OUT_DEPTH-1 and stage-1 holds last=1 and not popping).
REQ-023 SHALL pop on out_valid&&out_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 SHALL never push when full; out_valid = buffer non-empty; out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL set overflow when an addition carries beyond PSUM_SIZE bits; cleared only by reset.

Reset
REQ-026 SHALL, on rst=0, asynchronously clear: FSM->IDLE, acc=0, stage-1 valid=0, buffer empty, out_valid=0, out_data=0, stall=0, overflow=0, busy=0; an open window is discarded.

Configuration
REQ-027 SHALL, with MAC_PSUM_SAT_EN defined, saturate acc at 2^PSUM_SIZE-1 on overflow; without it, wrap modulo 2^PSUM_SIZE. overflow flag behaves identically in both.

Structure
REQ-028 SHALL place FSM state type and PSUM_SIZE default in package mac_psum_pkg.
REQ-029 SHALL implement the output buffer as sub-module psum_out_fifo (push, pop, count, full, empty).

Verification
REQ-030 Pairs (2,3),(4,5),(1,7), par_done on third, out_ready=1 -> out_data=33, out_valid high 2 edges after third pair, one cycle.
REQ-031 out_ready=0, five one-pair windows (1,1)..(5,1), OUT_DEPTH=4 -> stall high once 4 sums held, fifth pair held off; raise out_ready -> outputs 1,2,3,4,5 in order.
REQ-032 PSUM_SIZE=16, two pairs (255,255) one window -> 65535 with MAC_PSUM_SAT_EN, 64514 without; overflow=1 both.
REQ-033 Two pairs of open window then rst=0 one cycle -> all outputs zero; next window (3,3) par_done=1 -> out_data=9, overflow=0.
REQ-034 count=OUT_DEPTH-1, pop and push same edge -> count stays OUT_DEPTH-1, stall=0, FIFO order preserved.
